// File: rtl/mamba2_pkg.sv
// Shared definitions for the Mamba-2 SSM output path: FP16 constants,
// sizing helpers and the state encodings used by the reduction controller.
package mamba2_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        LN_IDLE  = 2'd0,
        LN_ISSUE = 2'd1,
        LN_WAIT  = 2'd2
    } lane_phase_t;

    function automatic int rows_of(input int b, input int h, input int p);
        return b * h * p;
    endfunction

    function automatic int rounds_of(input int rows, input int par);
        return (rows + par - 1) / par;
    endfunction

    function automatic int idx_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/fp16_add_wrapper.sv
// Pipelined IEEE FP16 adder: round-to-nearest-even, gradual underflow,
// canonical quiet NaN. Result appears A_LAT cycles after valid_in is sampled.
module fp16_add_wrapper
    import mamba2_pkg::*;
#(
    parameter int A_LAT = 6
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        valid_in,
    output logic [15:0] result,
    output logic        valid_out
);

    function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
        logic        x_nan, y_nan, x_inf, y_inf;
        logic [15:0] big, sml;
        logic [5:0]  e_big, e_sml, e_dif, e_res;
        logic [13:0] m_big, m_sml, m_aln, norm;
        logic [14:0] sum, base;
        logic        sticky, rnd_up;
        logic [15:0] res;

        x_nan = (&x[14:10]) & (|x[9:0]);
        y_nan = (&y[14:10]) & (|y[9:0]);
        x_inf = (&x[14:10]) & ~(|x[9:0]);
        y_inf = (&y[14:10]) & ~(|y[9:0]);
        res   = FP16_QNAN;

        if (x_nan || y_nan) begin
            res = FP16_QNAN;
        end else if (x_inf && y_inf) begin
            res = (x[15] == y[15]) ? x : FP16_QNAN;
        end else if (x_inf) begin
            res = x;
        end else if (y_inf) begin
            res = y;
        end else begin
            if (x[14:0] >= y[14:0]) begin
                big = x;
                sml = y;
            end else begin
                big = y;
                sml = x;
            end
            // Subnormals share the exponent of the smallest normal, hidden bit 0.
            e_big = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
            e_sml = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
            m_big = {(big[14:10] != 5'd0), big[9:0], 3'b000};
            m_sml = {(sml[14:10] != 5'd0), sml[9:0], 3'b000};
            e_dif = e_big - e_sml;

            if (e_dif >= 6'd14) begin
                m_aln  = 14'd0;
                sticky = |m_sml;
            end else begin
                m_aln  = m_sml >> e_dif;
                sticky = |(m_sml & ~(14'h3FFF << e_dif));
            end
            m_aln[0] = m_aln[0] | sticky;

            if (big[15] == sml[15]) begin
                sum = {1'b0, m_big} + {1'b0, m_aln};
            end else begin
                sum = {1'b0, m_big} - {1'b0, m_aln};
            end

            e_res = e_big;
            if (sum[14]) begin
                norm  = {sum[14:2], sum[1] | sum[0]};
                e_res = e_big + 6'd1;
            end else begin
                norm = sum[13:0];
                for (int i = 0; i < 13; i++) begin
                    if (!norm[13] && e_res > 6'd1) begin
                        norm  = norm << 1;
                        e_res = e_res - 6'd1;
                    end
                end
            end

            if (sum == 15'd0) begin
                res = {big[15] & sml[15], 15'd0};
            end else if (e_res >= 6'd31) begin
                res = {big[15], FP16_INF[14:0]};
            end else begin
                // Rounding carry ripples into the exponent field (and on to Inf).
                base   = {(norm[13] ? e_res[4:0] : 5'd0), norm[12:3]};
                rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
                res    = {big[15], base + {14'd0, rnd_up}};
            end
        end
        return res;
    endfunction

    logic [15:0]      res_pipe [A_LAT];
    logic [A_LAT-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        res_pipe[0] <= fp16_add(a, b);
        vld_pipe[0] <= valid_in;
        for (int i = 1; i < A_LAT; i++) begin
            res_pipe[i] <= res_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign result    = res_pipe[A_LAT-1];
    assign valid_out = vld_pipe[A_LAT-1];

endmodule

// File: rtl/hc_reduce_y.sv
// Reduces h*C products over the state dimension and adds the skip term:
// y[r] = Dx[r] + sum_n hC[r,n], on PAR lockstep FP16 accumulate lanes.
//
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | rounds of lane issue/wait until every row is reduced
//   DONE    | one-cycle completion pulse
module hc_reduce_y
    import mamba2_pkg::*;
#(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int A_LAT = 6,
    parameter int PAR   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [B*H*P*N*DW-1:0] hC_flat,
    input  logic [B*H*P*DW-1:0]   Dx_flat,
    output logic [B*H*P*DW-1:0]   y_flat,
    output logic                  busy,
    output logic                  done
);

    localparam int ROWS  = rows_of(B, H, P);
    localparam int R     = rounds_of(ROWS, PAR);
    localparam int RND_W = idx_w(R);
    localparam int NW    = idx_w(N);

    top_state_t  state, state_nxt;
    lane_phase_t phase, phase_nxt;
    logic [RND_W-1:0] rnd_idx, rnd_nxt;
    logic [NW-1:0]    n_cnt, n_nxt;
    logic             load_acc, issue, cap, wr_y, last_n, last_rnd;

    logic [PAR-1:0] add_vin;
    logic [PAR-1:0] add_vout;
    logic [DW-1:0]  add_res [PAR];

    // Lane 0 is active in every round, so its valid_out paces the whole array.
    assign cap      = (state == ST_RUN) && (phase == LN_WAIT) && add_vout[0];
    assign last_n   = (n_cnt == NW'(N - 1));
    assign last_rnd = (rnd_idx == RND_W'(R - 1));

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        rnd_nxt   = rnd_idx;
        n_nxt     = n_cnt;
        load_acc  = 1'b0;
        issue     = 1'b0;
        wr_y      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    phase_nxt = LN_ISSUE;
                    rnd_nxt   = '0;
                    n_nxt     = '0;
                    load_acc  = 1'b1;
                end
            end
            ST_RUN: begin
                case (phase)
                    LN_ISSUE: begin
                        issue     = 1'b1;
                        phase_nxt = LN_WAIT;
                    end
                    LN_WAIT: begin
                        if (cap) begin
                            if (last_n) begin
                                wr_y  = 1'b1;
                                n_nxt = '0;
                                if (last_rnd) begin
                                    phase_nxt = LN_IDLE;
                                end else begin
                                    rnd_nxt   = rnd_idx + RND_W'(1);
                                    load_acc  = 1'b1;
                                    phase_nxt = LN_ISSUE;
                                end
                            end else begin
                                n_nxt     = n_cnt + NW'(1);
                                phase_nxt = LN_ISSUE;
                            end
                        end
                    end
                    default: state_nxt = ST_DONE;
                endcase
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = LN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= LN_IDLE;
            rnd_idx <= '0;
            n_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            rnd_idx <= rnd_nxt;
            n_cnt   <= n_nxt;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    for (genvar k = 0; k < PAR; k++) begin : g_lane
        logic [DW-1:0] acc;
        logic [DW-1:0] dx_tab [R];
        logic [DW-1:0] hc_tab [R][N];
        logic          on_tab [R];

        for (genvar rn = 0; rn < R; rn++) begin : g_rnd
            localparam int ROW = rn * PAR + k;
            if (ROW < ROWS) begin : g_act
                assign dx_tab[rn] = Dx_flat[ROW*DW +: DW];
                assign on_tab[rn] = 1'b1;
                for (genvar nn = 0; nn < N; nn++) begin : g_n
                    assign hc_tab[rn][nn] = hC_flat[(ROW*N + nn)*DW +: DW];
                end
            end else begin : g_pad
                assign dx_tab[rn] = FP16_ZERO;
                assign on_tab[rn] = 1'b0;
                for (genvar nn = 0; nn < N; nn++) begin : g_n
                    assign hc_tab[rn][nn] = FP16_ZERO;
                end
            end
        end

        assign add_vin[k] = issue & on_tab[rnd_idx];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= FP16_ZERO;
            end else if (load_acc) begin
                acc <= dx_tab[rnd_nxt];
            end else if (cap && add_vout[k]) begin
                acc <= add_res[k];
            end
        end

        fp16_add_wrapper #(.A_LAT(A_LAT)) u_add (
            .clk       (clk),
            .a         (acc),
            .b         (hc_tab[rnd_idx][n_cnt]),
            .valid_in  (add_vin[k]),
            .result    (add_res[k]),
            .valid_out (add_vout[k])
        );
    end

    // Each row is owned by a fixed (round, lane) pair, so its write enable is static.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int LANE = r % PAR;
        localparam int RND  = r / PAR;
        logic [DW-1:0] y_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_q <= FP16_ZERO;
            end else if (wr_y && (rnd_idx == RND_W'(RND))) begin
                y_q <= add_res[LANE];
            end
        end

        assign y_flat[r*DW +: DW] = y_q;
    end

endmodule

// File: tb/tb_hc_reduce_y.sv
// Self-checking bench for hc_reduce_y: PAR=4 and PAR=3 instances share inputs;
// results are checked against a real-arithmetic FP16 reference.
module tb_hc_reduce_y;

    localparam int B = 1, H = 4, P = 4, N = 4, DW = 16, A_LAT = 6;
    localparam int ROWS = B * H * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0;
    logic start3 = 1'b0;
    logic [ROWS*N*DW-1:0] hC_flat = '0;
    logic [ROWS*DW-1:0]   Dx_flat = '0;
    logic [ROWS*DW-1:0]   y4, y3;
    logic busy4, done4, busy3, done3;

    always #5 clk = ~clk;

    hc_reduce_y #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .A_LAT(A_LAT), .PAR(4)) dut (
        .clk(clk), .rst(rst), .start(start4), .hC_flat(hC_flat), .Dx_flat(Dx_flat),
        .y_flat(y4), .busy(busy4), .done(done4)
    );

    hc_reduce_y #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .A_LAT(A_LAT), .PAR(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .hC_flat(hC_flat), .Dx_flat(Dx_flat),
        .y_flat(y3), .busy(busy3), .done(done3)
    );

    logic [15:0] hc_m  [ROWS][N];
    logic [15:0] dx_m  [ROWS];
    logic [15:0] exp_y [ROWS];
    int total = 0;
    int bad   = 0;

    function automatic real fp16_to_real(input logic [15:0] v);
        int  e, m;
        real mag;
        e = int'(v[14:10]);
        m = int'(v[9:0]);
        if (e == 0) mag = real'(m) * 2.0 ** (-24);
        else        mag = real'(1024 + m) * 2.0 ** (e - 25);
        return v[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real x, input bit neg_zero);
        bit  s;
        real mag, scaled, fr;
        int  e, ip, bits;
        if (x == 0.0) return neg_zero ? 16'h8000 : 16'h0000;
        s   = (x < 0.0);
        mag = s ? -x : x;
        if (mag < 2.0 ** (-14)) begin
            bits = $rtoi(mag * 2.0 ** 24);
        end else begin
            e = -14;
            while (mag >= 2.0 ** (e + 1)) e++;
            scaled = mag * 2.0 ** (10 - e);
            ip = $rtoi(scaled);
            fr = scaled - real'(ip);
            if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
            bits = ((e + 15) << 10) + (ip - 1024);
            if (bits >= 31 * 1024) bits = 31 * 1024;
        end
        return {s, 15'(bits)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        return real_to_fp16(fp16_to_real(a) + fp16_to_real(b), a[15] & b[15]);
    endfunction

    function automatic logic [15:0] rand_fp16();
        int k;
        logic s;
        k = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        if (k == 0) return {s, 15'd0};
        if (k == 1) return {s, 5'd0, 10'($urandom_range(1, 1023))};
        return {s, 5'($urandom_range(8, 20)), 10'($urandom_range(0, 1023))};
    endfunction

    task automatic randomize_data();
        for (int r = 0; r < ROWS; r++) begin
            dx_m[r] = rand_fp16();
            for (int n = 0; n < N; n++) hc_m[r][n] = rand_fp16();
        end
    endtask

    task automatic apply_data();
        for (int r = 0; r < ROWS; r++) begin
            Dx_flat[r*DW +: DW] = dx_m[r];
            for (int n = 0; n < N; n++) hC_flat[(r*N + n)*DW +: DW] = hc_m[r][n];
            exp_y[r] = dx_m[r];
            for (int n = 0; n < N; n++) exp_y[r] = ref_add(exp_y[r], hc_m[r][n]);
        end
    endtask

    // Starts one run, then watches it cycle by cycle (cycle 0 = start high).
    task automatic run_op(input bit use3, input int exp_done, input int start2_at,
                          output int done_at, output int done_cnt, output int busy_err,
                          output int vin0_cnt, output int gap_err,
                          output int vin1_cnt, output int vin1_last);
        int  last0;
        logic d, bz, v0, v1;
        last0 = -1;
        done_at = -1; done_cnt = 0; busy_err = 0;
        vin0_cnt = 0; gap_err = 0; vin1_cnt = 0; vin1_last = -1;
        @(posedge clk); #1;
        if (use3) start3 = 1'b1; else start4 = 1'b1;
        for (int cyc = 1; cyc <= 260; cyc++) begin
            @(posedge clk); #1;
            start3 = 1'b0;
            start4 = 1'b0;
            if (cyc == start2_at) begin
                if (use3) start3 = 1'b1; else start4 = 1'b1;
            end
            d  = use3 ? done3 : done4;
            bz = use3 ? busy3 : busy4;
            v0 = use3 ? dut3.add_vin[0] : dut.add_vin[0];
            v1 = use3 ? dut3.add_vin[1] : dut.add_vin[1];
            if (d === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (bz !== ((cyc >= 1) && (cyc < exp_done))) busy_err++;
            if (v0 === 1'b1) begin
                if (last0 >= 0 && (cyc - last0) != A_LAT + 1) gap_err++;
                last0 = cyc;
                vin0_cnt++;
            end
            if (v1 === 1'b1) begin
                vin1_cnt++;
                vin1_last = cyc;
            end
            if (done_at >= 0 && cyc >= done_at + 4) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", busy4); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done4 got=%b want=0", done4); end
        total++; if (y4 !== '0) begin bad++; $display("FAIL reset_y4 got=%h want=0", y4); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy3 got=%b want=0", busy3); end
        total++; if (y3 !== '0) begin bad++; $display("FAIL reset_y3 got=%h want=0", y3); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ones();
        int da, dc, be, v0c, ge, v1c, v1l;
        for (int r = 0; r < ROWS; r++) begin
            dx_m[r] = 16'h3C00;
            for (int n = 0; n < N; n++) hc_m[r][n] = 16'h3C00;
        end
        apply_data();
        run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (da !== 114) begin bad++; $display("FAIL ones_done_cycle got=%0d want=114", da); end
        total++; if (dc !== 1) begin bad++; $display("FAIL ones_done_pulses got=%0d want=1", dc); end
        total++; if (be !== 0) begin bad++; $display("FAIL ones_busy_window bad_cycles=%0d want=0", be); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y4[r*DW +: DW] !== 16'h4500) begin
                bad++; $display("FAIL ones_y[%0d] got=%h want=4500", r, y4[r*DW +: DW]);
            end
        end
    endtask

    task automatic test_half();
        int da, dc, be, v0c, ge, v1c, v1l;
        for (int r = 0; r < ROWS; r++) begin
            dx_m[r] = 16'h0000;
            for (int n = 0; n < N; n++) hc_m[r][n] = 16'h3800;
        end
        apply_data();
        run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (ge !== 0) begin bad++; $display("FAIL half_issue_gap bad_gaps=%0d want=0", ge); end
        total++; if (v0c !== 16) begin bad++; $display("FAIL half_issue_count got=%0d want=16", v0c); end
        total++; if (da !== 114) begin bad++; $display("FAIL half_done_cycle got=%0d want=114", da); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y4[r*DW +: DW] !== 16'h4000) begin
                bad++; $display("FAIL half_y[%0d] got=%h want=4000", r, y4[r*DW +: DW]);
            end
        end
    endtask

    task automatic test_mixed();
        int da, dc, be, v0c, ge, v1c, v1l;
        randomize_data();
        dx_m[5] = 16'h4200;
        hc_m[5][0] = 16'h3C00; hc_m[5][1] = 16'hBC00;
        hc_m[5][2] = 16'h4000; hc_m[5][3] = 16'hC000;
        apply_data();
        run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (y4[5*DW +: DW] !== 16'h4200) begin bad++; $display("FAIL mixed_row5 got=%h want=4200", y4[5*DW +: DW]); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y4[r*DW +: DW] !== exp_y[r]) begin
                bad++; $display("FAIL mixed_y[%0d] got=%h want=%h", r, y4[r*DW +: DW], exp_y[r]);
            end
        end
    endtask

    task automatic test_par3();
        int da, dc, be, v0c, ge, v1c, v1l;
        randomize_data();
        apply_data();
        run_op(1'b1, 170, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (da !== 170) begin bad++; $display("FAIL par3_done_cycle got=%0d want=170", da); end
        total++; if (dc !== 1) begin bad++; $display("FAIL par3_done_pulses got=%0d want=1", dc); end
        total++; if (be !== 0) begin bad++; $display("FAIL par3_busy_window bad_cycles=%0d want=0", be); end
        total++; if (v0c !== 24) begin bad++; $display("FAIL par3_lane0_issues got=%0d want=24", v0c); end
        total++; if (v1c !== 20) begin bad++; $display("FAIL par3_lane1_issues got=%0d want=20", v1c); end
        total++; if (v1l >= 141) begin bad++; $display("FAIL par3_lane1_last_issue got=%0d want<141", v1l); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y3[r*DW +: DW] !== exp_y[r]) begin
                bad++; $display("FAIL par3_y[%0d] got=%h want=%h", r, y3[r*DW +: DW], exp_y[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int da, dc, be, v0c, ge, v1c, v1l, late_done;
        randomize_data();
        apply_data();
        @(posedge clk); #1;
        start4 = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy4); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done4); end
        total++; if (y4 !== '0) begin bad++; $display("FAIL midrst_y got=%h want=0", y4); end
        rst = 1'b0;
        late_done = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1 || busy4 === 1'b1) late_done++;
        end
        total++; if (late_done !== 0) begin bad++; $display("FAIL midrst_no_resume got=%0d want=0", late_done); end
        run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (da !== 114) begin bad++; $display("FAIL midrst_rerun_done got=%0d want=114", da); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y4[r*DW +: DW] !== exp_y[r]) begin
                bad++; $display("FAIL midrst_y[%0d] got=%h want=%h", r, y4[r*DW +: DW], exp_y[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int da, dc, be, v0c, ge, v1c, v1l;
        logic [ROWS*DW-1:0] held;
        randomize_data();
        apply_data();
        run_op(1'b0, 114, 20, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (da !== 114) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=114", da); end
        total++; if (dc !== 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=1", dc); end
        total++; if (be !== 0) begin bad++; $display("FAIL b2b_busy_window bad_cycles=%0d want=0", be); end
        for (int r = 0; r < ROWS; r++) held[r*DW +: DW] = exp_y[r];
        for (int r = 0; r < ROWS; r++) dx_m[r] = rand_fp16();
        apply_data();
        repeat (5) @(posedge clk);
        #1;
        total++; if (y4 !== held) begin bad++; $display("FAIL b2b_hold got=%h want=%h", y4, held); end
        run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
        total++; if (dc !== 1) begin bad++; $display("FAIL b2b_second_done got=%0d want=1", dc); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (y4[r*DW +: DW] !== exp_y[r]) begin
                bad++; $display("FAIL b2b_y[%0d] got=%h want=%h", r, y4[r*DW +: DW], exp_y[r]);
            end
        end
    endtask

    task automatic test_random();
        int da, dc, be, v0c, ge, v1c, v1l;
        for (int it = 0; it < 3; it++) begin
            randomize_data();
            apply_data();
            run_op(1'b0, 114, -1, da, dc, be, v0c, ge, v1c, v1l);
            run_op(1'b1, 170, -1, da, dc, be, v0c, ge, v1c, v1l);
            for (int r = 0; r < ROWS; r++) begin
                total++;
                if (y4[r*DW +: DW] !== exp_y[r]) begin
                    bad++; $display("FAIL rand%0d_y4[%0d] got=%h want=%h", it, r, y4[r*DW +: DW], exp_y[r]);
                end
                total++;
                if (y3[r*DW +: DW] !== exp_y[r]) begin
                    bad++; $display("FAIL rand%0d_y3[%0d] got=%h want=%h", it, r, y3[r*DW +: DW], exp_y[r]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_half();
        test_mixed();
        test_par3();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
